pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline register for the five-stage CPU datapath. It generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches into one block.
- Configurable payload width and depth (1..4 chained slots).
- Per-slot valid bits, priority-resolved flush/stall/advance.
- Sticky halt freeze.
- Optional bubble/stall performance counters.
Instantiated between adjacent stages, with the advance enable driven by the hazard unit and ihit/dhit.

Parameters:
DATA_W, 128, payload width in bits (1..512)
DEPTH, 1, number of chained register slots (1..4); latency in advance cycles
HALT_BIT, 0, payload bit index carrying the halt flag (0..DATA_W-1)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous, active-low reset
en  input  1  advance request (ihit|dhit from the cache interface)
stall  input  1  hold all slots (hazard unit)
flush  input  1  squash all slots to bubbles (branch/jump resolution)
in_valid  input  1  incoming payload is a real instruction
in_data  input  DATA_W  incoming payload
out_valid  output  1  valid bit of last slot
out_data  output  DATA_W  payload of last slot
halted  output  1  sticky: a valid halt reached the last slot
occupancy  output  3  count of valid slots (0..DEPTH)
bubble_cnt  output  32  bubbles shifted out of last slot (BUBBLE_COUNT_EN only, else tied 0)
stall_cnt  output  32  cycles with stall=1 and en=1 (BUBBLE_COUNT_EN only, else tied 0)

Behaviour:
- Reset (nRST=0, async):
  - All slot data <= 0, valid <= 0, halted <= 0, counters <= 0.
  - Outputs read 0 on the same edge as the reset assertion.
- Slots S[0]..S[DEPTH-1]. out_data/out_valid come directly from the S[DEPTH-1] flops; no combinational path from any input to any output.
- Per-edge action, priority highest first:
  1. halted=1: freeze. No slot changes, regardless of flush/stall/en. Counters also freeze.
  2. flush=1: every slot data <= 0, valid <= 0. Overrides stall and en in the same cycle.
  3. stall=1: hold all slots.
  4. en=1: shift. S[0] <= {in_valid, in_data}; S[i] <= S[i-1].
  5. Otherwise: hold.
- Bubble data: when in_valid=0 on a shift, S[0].data <= 0 (not in_data), so downstream decode sees a zero-filled no-op.
- Halt:
  - halted sets on the edge after S[DEPTH-1] holds valid=1 with data[HALT_BIT]=1.
  - Once set, it stays set until reset.
  - A halt in a slot that is flushed before reaching S[DEPTH-1] never sets halted.
- occupancy: registered population count of the slot valid bits, updated on the same edge as the slots. Width 3 covers DEPTH=4.
- Latency: an item accepted on a shift appears at out_data after exactly DEPTH shift edges. Stalled or idle cycles do not count.
- DEPTH=1 is cycle-equivalent to a classic hit-enabled pipeline latch with added valid/flush/stall.
- Parameter checks: elaboration-time error if DEPTH is outside 1..4 or HALT_BIT >= DATA_W.

Optional Feature:
BUBBLE_COUNT_EN defined:
- bubble_cnt increments on each shift edge where the outgoing S[DEPTH-1] has valid=0 and no flush occurs.
- stall_cnt increments on each edge with stall=1, en=1, flush=0.
- Both are 32-bit, wrap from 0xFFFFFFFF to 0, and hold while halted.

BUBBLE_COUNT_EN undefined:
- No counter flops are built; bubble_cnt and stall_cnt are tied to 0.

Test Plan:
- Reset: DEPTH=2, drive nRST=0 mid-stream with both slots valid -> out_valid=0, out_data=0, occupancy=0, halted=0 immediately, without waiting for a clock edge.
- Latency: DEPTH=3, en=1 every cycle, in_data=0xA1,0xA2,0xA3 with in_valid=1 -> out_data=0xA1 on the 3rd edge, then 0xA2, 0xA3; occupancy ramps 1,2,3.
- Stall vs. flush: DEPTH=2 full with 0x11/0x22, stall=1 and en=1 for 3 cycles -> outputs hold 0x22. Then flush=1 together with stall=1 -> both slots cleared, occupancy=0.
- Bubble: in_valid=0, in_data=0xFFFF, en=1 -> S[0] data=0, valid=0. With BUBBLE_COUNT_EN, bubble_cnt=1 after the bubble exits S[DEPTH-1].
- Halt: DEPTH=1, HALT_BIT=0, shift in 0x1 valid -> halted=1 one edge later. Subsequent en/flush leave out_data=0x1.
  - Separately, a halt flushed in S[0] with DEPTH=2 -> halted stays 0.
- Counter wrap: BUBBLE_COUNT_EN, force stall_cnt to 0xFFFFFFFF, then one stall+en edge -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline register for the five-stage CPU datapath.
// Replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches with DEPTH chained slots,
// each carrying a valid bit and a DATA_W payload.
//
// Per-edge priority: halted (freeze) > flush (squash) > stall (hold) > en (shift) > hold.
// Items shifted in with in_valid=0 become zero-filled bubbles.
// A valid item with data[HALT_BIT]=1 in the last slot sets the sticky halted flag on the
// following edge.
//
// Optional build macro:
//   BUBBLE_COUNT_EN - builds the bubble/stall counters; when undefined both read 0.
//
// Ports:
//   CLK        rising-edge clock
//   nRST       asynchronous active-low reset
//   en         advance request (ihit|dhit)
//   stall      hold all slots
//   flush      squash all slots to bubbles
//   in_valid   incoming payload is a real instruction
//   in_data    incoming payload
//   out_valid  valid bit of the last slot
//   out_data   payload of the last slot
//   halted     sticky halt seen at the last slot
//   occupancy  number of valid slots
//   bubble_cnt bubbles shifted out of the last slot
//   stall_cnt  cycles with stall and en both requested (no flush)
module pipe_stage_reg #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned DEPTH    = 1,
  parameter int unsigned HALT_BIT = 0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              halted,
  output logic [2:0]        occupancy,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       stall_cnt
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
    $error("pipe_stage_reg: DEPTH must be within 1..4");
  end
  if (DATA_W < 1 || DATA_W > 512) begin : g_width_chk
    $error("pipe_stage_reg: DATA_W must be within 1..512");
  end
  if (HALT_BIT >= DATA_W) begin : g_halt_chk
    $error("pipe_stage_reg: HALT_BIT must be below DATA_W");
  end

  localparam int unsigned Last = DEPTH - 1;

  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic                         halted_q, halted_d;
  logic [2:0]                   occ_q, occ_d;

  logic do_flush, do_stall, do_shift;

  // Decoded per-edge action; halted masks everything.
  always_comb begin
    do_flush = !halted_q && flush;
    do_stall = !halted_q && !flush && stall;
    do_shift = !halted_q && !flush && !stall && en;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (do_flush) begin
      data_d  = '0;
      valid_d = '0;
    end else if (do_shift) begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // Bubbles enter zero-filled so downstream decode sees a no-op.
      data_d[0]  = in_valid ? in_data : '0;
      valid_d[0] = in_valid;
    end
  end

  // Halt is judged on the last slot's current contents, independent of this edge's action.
  always_comb begin
    halted_d = halted_q | (valid_q[Last] & data_q[Last][HALT_BIT]);
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_d = occ_d + 3'(valid_d[i]);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      data_q   <= '0;
      valid_q  <= '0;
      halted_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      occ_q    <= occ_d;
    end
  end

  always_comb begin
    out_valid = valid_q[Last];
    out_data  = data_q[Last];
    halted    = halted_q;
    occupancy = occ_q;
  end

`ifdef BUBBLE_COUNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Both counters wrap naturally at 32 bits and freeze while halted via do_*.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (do_shift && !valid_q[Last]) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
    if (do_stall && en) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  always_comb begin
    bubble_cnt = bubble_cnt_q;
    stall_cnt  = stall_cnt_q;
  end
`else
  always_comb begin
    bubble_cnt = '0;
    stall_cnt  = '0;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (DEPTH 1, 2, 3; DATA_W 16) share one stimulus
// stream. Directed tasks check the targeted instance against fixed values; the random task
// compares every instance against a slot-array reference model.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;
`ifdef BUBBLE_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          en = 1'b0, stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;

  always #5 CLK = ~CLK;

  logic          ov [3];
  logic [DW-1:0] od [3];
  logic          hl [3];
  logic [2:0]    oc [3];
  logic [31:0]   bc [3];
  logic [31:0]   sc [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic          v, h;
    logic [DW-1:0] d;
    logic [2:0]    o;
    logic [31:0]   b, s;
    pipe_stage_reg #(
      .DATA_W  (DW),
      .DEPTH   (g + 1),
      .HALT_BIT((g == 0) ? 0 : 15)
    ) u_dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .en        (en),
      .stall     (stall),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (v),
      .out_data  (d),
      .halted    (h),
      .occupancy (o),
      .bubble_cnt(b),
      .stall_cnt (s)
    );
    assign ov[g] = v;
    assign od[g] = d;
    assign hl[g] = h;
    assign oc[g] = o;
    assign bc[g] = b;
    assign sc[g] = s;
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: instance k has k+1 slots; slot k is the output slot.
  logic          mv [3][4];
  logic [DW-1:0] md [3][4];
  logic          mh [3];
  logic [31:0]   mb [3];
  logic [31:0]   ms [3];

  function automatic int unsigned hbit(int k);
    return (k == 0) ? 0 : 15;
  endfunction

  function automatic logic [2:0] m_occ(int k);
    int n = 0;
    for (int i = 0; i <= k; i++) n += int'(mv[k][i]);
    return 3'(n);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        mv[k][i] = 1'b0;
        md[k][i] = '0;
      end
      mh[k] = 1'b0;
      mb[k] = '0;
      ms[k] = '0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      bit halt_now;
      if (!mh[k]) begin
        halt_now = mv[k][k] && md[k][k][hbit(k)];
        if (flush) begin
          for (int i = 0; i <= k; i++) begin
            mv[k][i] = 1'b0;
            md[k][i] = '0;
          end
        end else if (stall) begin
          if (en && CntEn) ms[k] = ms[k] + 32'd1;
        end else if (en) begin
          if (!mv[k][k] && CntEn) mb[k] = mb[k] + 32'd1;
          // Item at the end drops out; everything moves one place toward the output.
          for (int i = k; i > 0; i--) begin
            mv[k][i] = mv[k][i-1];
            md[k][i] = md[k][i-1];
          end
          mv[k][0] = in_valid;
          md[k][0] = in_valid ? in_data : '0;
        end
        if (halt_now) mh[k] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    en = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (ov[k] !== 1'b0 || od[k] !== '0 || oc[k] !== 3'd0 || hl[k] !== 1'b0)
        $display("FAIL reset_state[%0d]: got v=%0b d=%0h occ=%0d h=%0b expected all 0",
                 k, ov[k], od[k], oc[k], hl[k]);
      else n_pass++;
      n_chk++;
      if (bc[k] !== 32'd0 || sc[k] !== 32'd0)
        $display("FAIL reset_cnt[%0d]: got %0h/%0h expected 0/0", k, bc[k], sc[k]);
      else n_pass++;
    end
    en = 1'b1; in_valid = 1'b1;
    in_data = 16'h0B0B; tick();
    in_data = 16'h0C0C; tick();
    en = 1'b0; in_valid = 1'b0;
    n_chk++;
    if (ov[1] !== 1'b1 || oc[1] !== 3'd2)
      $display("FAIL reset_prefill: got v=%0b occ=%0d expected 1/2", ov[1], oc[1]);
    else n_pass++;
    #2 nRST = 1'b0;
    #1;
    n_chk++;
    if (ov[1] !== 1'b0) $display("FAIL async_rst_valid: got %0b expected 0", ov[1]);
    else n_pass++;
    n_chk++;
    if (od[1] !== '0) $display("FAIL async_rst_data: got %0h expected 0", od[1]);
    else n_pass++;
    n_chk++;
    if (oc[1] !== 3'd0) $display("FAIL async_rst_occ: got %0d expected 0", oc[1]);
    else n_pass++;
    n_chk++;
    if (hl[1] !== 1'b0) $display("FAIL async_rst_halt: got %0b expected 0", hl[1]);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_latency();
    logic [DW-1:0] seq [3];
    seq[0] = 16'h00A1; seq[1] = 16'h00A2; seq[2] = 16'h00A3;
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      in_valid = (e <= 3);
      in_data  = (e <= 3) ? seq[e-1] : 16'h0;
      tick();
      n_chk++;
      if (oc[2] !== 3'((e <= 3) ? e : 6 - e))
        $display("FAIL lat_occ edge %0d: got %0d expected %0d", e, oc[2], (e <= 3) ? e : 6 - e);
      else n_pass++;
      n_chk++;
      if (ov[2] !== (e >= 3))
        $display("FAIL lat_valid edge %0d: got %0b expected %0b", e, ov[2], e >= 3);
      else n_pass++;
      if (e >= 3) begin
        n_chk++;
        if (od[2] !== seq[e-3])
          $display("FAIL lat_data edge %0d: got %0h expected %0h", e, od[2], seq[e-3]);
        else n_pass++;
      end
    end
    en = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_stall_flush();
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    in_data = 16'h0022; tick();
    in_data = 16'h0011; tick();
    stall = 1'b1; in_data = 16'h0033;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (ov[1] !== 1'b1 || od[1] !== 16'h0022 || oc[1] !== 3'd2)
        $display("FAIL stall_hold cyc %0d: got v=%0b d=%0h occ=%0d expected 1/22/2",
                 c, ov[1], od[1], oc[1]);
      else n_pass++;
    end
    n_chk++;
    if (sc[1] !== (CntEn ? 32'd3 : 32'd0))
      $display("FAIL stall_cnt: got %0d expected %0d", sc[1], CntEn ? 3 : 0);
    else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0; en = 1'b0;
    n_chk++;
    if (ov[1] !== 1'b0 || od[1] !== '0 || oc[1] !== 3'd0)
      $display("FAIL flush_clear: got v=%0b d=%0h occ=%0d expected 0/0/0", ov[1], od[1], oc[1]);
    else n_pass++;
    n_chk++;
    if (sc[1] !== (CntEn ? 32'd3 : 32'd0))
      $display("FAIL flush_no_stall_cnt: got %0d expected %0d", sc[1], CntEn ? 3 : 0);
    else n_pass++;
  endtask

  task automatic test_bubble();
    do_reset();
    en = 1'b1; in_valid = 1'b0; in_data = 16'hFFFF;
    tick();
    n_chk++;
    if (ov[0] !== 1'b0 || od[0] !== '0)
      $display("FAIL bubble_s0: got v=%0b d=%0h expected 0/0", ov[0], od[0]);
    else n_pass++;
    n_chk++;
    if (bc[0] !== (CntEn ? 32'd1 : 32'd0))
      $display("FAIL bubble_cnt: got %0d expected %0d", bc[0], CntEn ? 1 : 0);
    else n_pass++;
    tick();
    en = 1'b0;
    n_chk++;
    if (ov[1] !== 1'b0 || od[1] !== '0 || oc[1] !== 3'd0)
      $display("FAIL bubble_d2: got v=%0b d=%0h occ=%0d expected 0/0/0", ov[1], od[1], oc[1]);
    else n_pass++;
  endtask

  task automatic test_halt();
    do_reset();
    en = 1'b1; in_valid = 1'b1; in_data = 16'h0001;
    tick();
    en = 1'b0; in_valid = 1'b0;
    n_chk++;
    if (ov[0] !== 1'b1 || od[0] !== 16'h0001 || hl[0] !== 1'b0)
      $display("FAIL halt_pre: got v=%0b d=%0h h=%0b expected 1/1/0", ov[0], od[0], hl[0]);
    else n_pass++;
    tick();
    n_chk++;
    if (hl[0] !== 1'b1) $display("FAIL halt_set: got %0b expected 1", hl[0]);
    else n_pass++;
    en = 1'b1; in_valid = 1'b1; in_data = 16'h0006;
    tick();
    en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_chk++;
    if (ov[0] !== 1'b1 || od[0] !== 16'h0001 || hl[0] !== 1'b1)
      $display("FAIL halt_freeze: got v=%0b d=%0h h=%0b expected 1/1/1", ov[0], od[0], hl[0]);
    else n_pass++;
    n_chk++;
    if (bc[0] !== mb[0]) $display("FAIL halt_cnt_freeze: got %0d expected %0d", bc[0], mb[0]);
    else n_pass++;
    n_chk++;
    if (hl[1] !== 1'b0 || hl[2] !== 1'b0)
      $display("FAIL halt_other: got %0b/%0b expected 0/0", hl[1], hl[2]);
    else n_pass++;

    // Halt squashed in S[0] of the DEPTH=2 instance never reaches its output.
    do_reset();
    en = 1'b1; in_valid = 1'b1; in_data = 16'h8000;
    tick();
    en = 1'b0; in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (2) tick();
    n_chk++;
    if (hl[1] !== 1'b0 || oc[1] !== 3'd0)
      $display("FAIL halt_flushed: got h=%0b occ=%0d expected 0/0", hl[1], oc[1]);
    else n_pass++;
  endtask

`ifdef BUBBLE_COUNT_EN
  task automatic test_wrap();
    do_reset();
    force g_dut[1].u_dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release g_dut[1].u_dut.stall_cnt_q;
    en = 1'b1; stall = 1'b1;
    tick();
    en = 1'b0; stall = 1'b0;
    n_chk++;
    if (sc[1] !== 32'd0) $display("FAIL stall_wrap: got %0h expected 0", sc[1]);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en       = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = DW'($urandom) & 16'h7FFE;
      // Late in the run let halts through so freeze behaviour is exercised too.
      if (c > 300 && $urandom_range(0, 19) == 0) in_data[15] = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (ov[k] !== mv[k][k] || od[k] !== md[k][k])
          $display("FAIL rnd_out[%0d] cyc %0d: got %0b/%0h expected %0b/%0h",
                   k, c, ov[k], od[k], mv[k][k], md[k][k]);
        else n_pass++;
        n_chk++;
        if (oc[k] !== m_occ(k))
          $display("FAIL rnd_occ[%0d] cyc %0d: got %0d expected %0d", k, c, oc[k], m_occ(k));
        else n_pass++;
        n_chk++;
        if (hl[k] !== mh[k])
          $display("FAIL rnd_halt[%0d] cyc %0d: got %0b expected %0b", k, c, hl[k], mh[k]);
        else n_pass++;
        n_chk++;
        if (bc[k] !== mb[k] || sc[k] !== ms[k])
          $display("FAIL rnd_cnt[%0d] cyc %0d: got %0d/%0d expected %0d/%0d",
                   k, c, bc[k], sc[k], mb[k], ms[k]);
        else n_pass++;
      end
    end
    en = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_stall_flush();
    test_bubble();
    test_halt();
`ifdef BUBBLE_COUNT_EN
    test_wrap();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
